// File: rtl/median_pkg.sv
//------------------------------------------------------------------------------
// Module  : median_pkg
// Brief   : Shared window limits and pointer/count width helper.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package median_pkg;

   localparam int WIN_MIN = 3;
   localparam int WIN_MAX = 9;

   function automatic int cnt_w(input int win);
      return $clog2(win + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/clk_rst_intrfc.sv
//------------------------------------------------------------------------------
// Module  : clk_rst_intrfc
// Brief   : Clock and asynchronous active-low reset bundle.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface clk_rst_intrfc;

   logic clk;
   logic rstn;

   modport master (output clk, output rstn);
   modport slave  (input  clk, input  rstn);

endinterface

`default_nettype wire

// File: rtl/median_rank_sel.sv
//------------------------------------------------------------------------------
// Module  : median_rank_sel
// Brief   : Combinational selection of the middle-ranked window element.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module median_rank_sel #(
   parameter int DATA_W = 16,
   parameter int WIN    = 5,
   parameter int SIGNED = 0
) (
   input  logic [WIN*DATA_W-1:0] win_i,
   output logic [DATA_W-1:0]     sel_o
);

   localparam int            RW  = $clog2(WIN);
   localparam logic [RW-1:0] MID = RW'((WIN - 1) / 2);

   function automatic logic lt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      if (SIGNED != 0) return $signed(a) < $signed(b);
      else             return a < b;
   endfunction

   // Equal values are ordered by slot index, so every element owns a unique rank.
   always_comb begin
      logic [RW-1:0]     rank;
      logic [DATA_W-1:0] ei;
      logic [DATA_W-1:0] ej;
      sel_o = '0;
      rank  = '0;
      ei    = '0;
      ej    = '0;
      for (int i = 0; i < WIN; i++) begin
         ei   = win_i[i*DATA_W +: DATA_W];
         rank = '0;
         for (int j = 0; j < WIN; j++) begin
            ej = win_i[j*DATA_W +: DATA_W];
            if ((j != i) && (lt(ej, ei) || ((ej == ei) && (j < i))))
               rank = rank + 1'b1;
         end
         if (rank == MID)
            sel_o = ei;
      end
   end

endmodule

`default_nettype wire

// File: rtl/median_filter_n.sv
//------------------------------------------------------------------------------
// Module  : median_filter_n
// Brief   : Sliding-window median filter with bypass, flush and fill tracking.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module median_filter_n
   import median_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int WIN    = 5,
   parameter int SIGNED = 0
) (
   clk_rst_intrfc.slave      inst_in,
   input  logic [DATA_W-1:0] data_i,
   input  logic              data_av_sync,
   input  logic              flush_i,
   input  logic              bypass_i,
   output logic [DATA_W-1:0] median,
   output logic              median_en,
   output logic              window_full
);

   localparam int            CW     = cnt_w(WIN);
   localparam logic [CW-1:0] C_WIN  = CW'(WIN);
   localparam logic [CW-1:0] C_LAST = CW'(WIN - 1);

   generate
      if ((WIN < WIN_MIN) || (WIN > WIN_MAX) || ((WIN % 2) == 0)) begin : g_win_illegal
         $fatal(1, "median_filter_n: WIN must be odd and within 3..9");
      end
   endgenerate

   logic [DATA_W-1:0]     win_q [WIN];
   logic [DATA_W-1:0]     win_d [WIN];
   logic [CW-1:0]         ptr_q, ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  pend_q, pend_d;
   logic                  byp_q, byp_d;
   logic [DATA_W-1:0]     byp_data_q;
   logic [DATA_W-1:0]     median_q, median_d;
   logic                  median_en_q, median_en_d;
   logic [WIN*DATA_W-1:0] win_packed;
   logic [DATA_W-1:0]     rank_val;

   generate
      for (genvar g = 0; g < WIN; g++) begin : g_pack
         assign win_packed[g*DATA_W +: DATA_W] = win_q[g];
      end
   endgenerate

   median_rank_sel #(
      .DATA_W (DATA_W),
      .WIN    (WIN),
      .SIGNED (SIGNED)
   ) u_rank_sel (
      .win_i (win_packed),
      .sel_o (rank_val)
   );

   // Acceptance edge only records intent; the median is taken one edge later
   // from the registered window, keeping the sorter off the input path.
   always_comb begin
      win_d       = win_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      pend_d      = 1'b0;
      byp_d       = 1'b0;
      median_d    = median_q;
      median_en_d = pend_q;
      if (pend_q)
         median_d = byp_q ? byp_data_q : rank_val;
      if (flush_i) begin
         for (int i = 0; i < WIN; i++)
            win_d[i] = '0;
         ptr_d = '0;
         cnt_d = '0;
      end
      if (data_av_sync) begin
         win_d[ptr_d] = data_i;
         ptr_d        = (ptr_d == C_LAST) ? '0 : ptr_d + 1'b1;
         if (cnt_d != C_WIN)
            cnt_d = cnt_d + 1'b1;
         pend_d = bypass_i || (cnt_d == C_WIN);
         byp_d  = bypass_i;
      end
   end

   always_ff @(posedge inst_in.clk or negedge inst_in.rstn) begin
      if (!inst_in.rstn) begin
         for (int i = 0; i < WIN; i++)
            win_q[i] <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         byp_q       <= 1'b0;
         byp_data_q  <= '0;
         median_q    <= '0;
         median_en_q <= 1'b0;
      end else begin
         win_q       <= win_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         byp_q       <= byp_d;
         byp_data_q  <= data_i;
         median_q    <= median_d;
         median_en_q <= median_en_d;
      end
   end

   assign median      = median_q;
   assign median_en   = median_en_q;
   assign window_full = (cnt_q == C_WIN);

endmodule

`default_nettype wire

// File: tb/tb_median_filter_n.sv
//------------------------------------------------------------------------------
// Module  : tb_median_filter_n
// Brief   : Directed self-checking bench for median_filter_n.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_median_filter_n;

   clk_rst_intrfc cr ();

   logic [15:0] data;
   logic        stb, fl, byp;
   logic [15:0] m5, m3s, m3u;
   logic        e5, e3s, e3u;
   logic        f5, f3s, f3u;
   int          n_cmp = 0;
   int          n_err = 0;

   median_filter_n #(.DATA_W(16), .WIN(5), .SIGNED(0)) dut5 (
      .inst_in(cr), .data_i(data), .data_av_sync(stb), .flush_i(fl), .bypass_i(byp),
      .median(m5), .median_en(e5), .window_full(f5));

   median_filter_n #(.DATA_W(16), .WIN(3), .SIGNED(1)) dut3s (
      .inst_in(cr), .data_i(data), .data_av_sync(stb), .flush_i(fl), .bypass_i(byp),
      .median(m3s), .median_en(e3s), .window_full(f3s));

   median_filter_n #(.DATA_W(16), .WIN(3), .SIGNED(0)) dut3u (
      .inst_in(cr), .data_i(data), .data_av_sync(stb), .flush_i(fl), .bypass_i(byp),
      .median(m3u), .median_en(e3u), .window_full(f3u));

   initial cr.clk = 1'b0;
   always #5 cr.clk = ~cr.clk;

   task automatic push(input logic [15:0] d, input logic b, input logic f);
      data = d; byp = b; fl = f; stb = 1'b1;
      @(negedge cr.clk);
      stb = 1'b0; byp = 1'b0; fl = 1'b0;
   endtask

   task automatic do_flush();
      fl = 1'b1;
      @(negedge cr.clk);
      fl = 1'b0;
   endtask

   task automatic test_reset();
      cr.rstn = 1'b0; data = '0; stb = 1'b0; fl = 1'b0; byp = 1'b0;
      repeat (2) @(negedge cr.clk);
      n_cmp++; if ({m5, e5, f5} !== 18'd0) begin n_err++; $display("FAIL reset5 got m=%h e=%b f=%b want 0", m5, e5, f5); end
      n_cmp++; if ({m3s, e3s, f3s} !== 18'd0) begin n_err++; $display("FAIL reset3s got m=%h e=%b f=%b want 0", m3s, e3s, f3s); end
      n_cmp++; if ({m3u, e3u, f3u} !== 18'd0) begin n_err++; $display("FAIL reset3u got m=%h e=%b f=%b want 0", m3u, e3u, f3u); end
      cr.rstn = 1'b1;
      @(negedge cr.clk);
   endtask

   task automatic test_warmup();
      logic [15:0] seq [5] = '{16'd10, 16'd50, 16'd30, 16'd20, 16'd40};
      for (int k = 0; k < 5; k++) begin
         push(seq[k], 1'b0, 1'b0);
         @(negedge cr.clk);
         n_cmp++; if (e5 !== (k == 4)) begin n_err++; $display("FAIL warmup_en k=%0d got %b want %b", k, e5, (k == 4)); end
         n_cmp++; if (f5 !== (k == 4)) begin n_err++; $display("FAIL warmup_full k=%0d got %b want %b", k, f5, (k == 4)); end
      end
      n_cmp++; if (m5 !== 16'd30) begin n_err++; $display("FAIL warmup_median got %0d want 30", m5); end
      push(16'd60, 1'b0, 1'b0);
      @(negedge cr.clk);
      n_cmp++; if (e5 !== 1'b1 || m5 !== 16'd40) begin n_err++; $display("FAIL slide_60 got e=%b m=%0d want e=1 m=40", e5, m5); end
      @(negedge cr.clk);
      n_cmp++; if (e5 !== 1'b0 || m5 !== 16'd40) begin n_err++; $display("FAIL hold got e=%b m=%0d want e=0 m=40", e5, m5); end
   endtask

   task automatic test_signed();
      do_flush();
      push(16'hFFFF, 1'b0, 1'b0);
      @(negedge cr.clk);
      push(16'h0002, 1'b0, 1'b0);
      @(negedge cr.clk);
      n_cmp++; if (e3s !== 1'b0 || f3s !== 1'b0) begin n_err++; $display("FAIL signed_warm got e=%b f=%b want 0 0", e3s, f3s); end
      push(16'h0001, 1'b0, 1'b0);
      @(negedge cr.clk);
      n_cmp++; if (e3s !== 1'b1 || m3s !== 16'h0001) begin n_err++; $display("FAIL signed_med got e=%b m=%h want e=1 m=0001", e3s, m3s); end
      n_cmp++; if (e3u !== 1'b1 || m3u !== 16'h0002) begin n_err++; $display("FAIL unsigned_med got e=%b m=%h want e=1 m=0002", e3u, m3u); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] v  [7] = '{16'd7, 16'd7, 16'd3, 16'd7, 16'd3, 16'd9, 16'd1};
      logic [15:0] em [7] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7, 16'd7};
      do_flush();
      for (int k = 0; k < 7; k++) begin
         push(v[k], 1'b0, 1'b0);
         n_cmp++; if (e5 !== (k >= 5)) begin n_err++; $display("FAIL b2b_en k=%0d got %b want %b", k, e5, (k >= 5)); end
         if (k >= 5) begin
            n_cmp++; if (m5 !== em[k]) begin n_err++; $display("FAIL b2b_med k=%0d got %0d want %0d", k, m5, em[k]); end
         end
      end
      @(negedge cr.clk);
      n_cmp++; if (e5 !== 1'b1 || m5 !== 16'd3) begin n_err++; $display("FAIL b2b_last got e=%b m=%0d want e=1 m=3", e5, m5); end
      @(negedge cr.clk);
      n_cmp++; if (e5 !== 1'b0) begin n_err++; $display("FAIL b2b_idle got e=%b want 0", e5); end
   endtask

   task automatic test_bypass();
      push(16'h1234, 1'b1, 1'b0);
      @(negedge cr.clk);
      n_cmp++; if (e5 !== 1'b1 || m5 !== 16'h1234) begin n_err++; $display("FAIL bypass got e=%b m=%h want e=1 m=1234", e5, m5); end
      push(16'h0000, 1'b0, 1'b0);
      @(negedge cr.clk);
      n_cmp++; if (e5 !== 1'b1 || m5 !== 16'd3) begin n_err++; $display("FAIL post_bypass got e=%b m=%0d want e=1 m=3", e5, m5); end
   endtask

   task automatic test_flush();
      logic [15:0] v [4] = '{16'd5, 16'd6, 16'd7, 16'd8};
      push(16'd9, 1'b0, 1'b1);
      @(negedge cr.clk);
      n_cmp++; if (e5 !== 1'b0 || f5 !== 1'b0 || m5 !== 16'd3) begin n_err++; $display("FAIL flush got e=%b f=%b m=%0d want 0 0 3", e5, f5, m5); end
      for (int k = 0; k < 4; k++) begin
         push(v[k], 1'b0, 1'b0);
         n_cmp++; if (f5 !== (k == 3)) begin n_err++; $display("FAIL flush_fill k=%0d got %b want %b", k, f5, (k == 3)); end
         @(negedge cr.clk);
         n_cmp++; if (e5 !== (k == 3)) begin n_err++; $display("FAIL flush_en k=%0d got %b want %b", k, e5, (k == 3)); end
      end
      n_cmp++; if (m5 !== 16'd7) begin n_err++; $display("FAIL flush_med got %0d want 7", m5); end
   endtask

   task automatic test_bypass_warmup();
      do_flush();
      push(16'hABCD, 1'b1, 1'b0);
      @(negedge cr.clk);
      n_cmp++; if (e5 !== 1'b1 || m5 !== 16'hABCD || f5 !== 1'b0) begin n_err++; $display("FAIL byp_warm5 got e=%b m=%h f=%b want 1 abcd 0", e5, m5, f5); end
      n_cmp++; if (e3s !== 1'b1 || m3s !== 16'hABCD) begin n_err++; $display("FAIL byp_warm3 got e=%b m=%h want 1 abcd", e3s, m3s); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] v [5] = '{16'd11, 16'd22, 16'd33, 16'd44, 16'd55};
      push(16'd100, 1'b0, 1'b1);
      push(16'd200, 1'b0, 1'b0);
      push(16'd300, 1'b0, 1'b0);
      #2 cr.rstn = 1'b0;
      #1;
      n_cmp++; if ({m5, e5, f5} !== 18'd0) begin n_err++; $display("FAIL rst_mid got m=%h e=%b f=%b want 0", m5, e5, f5); end
      @(negedge cr.clk);
      cr.rstn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         push(v[k], 1'b0, 1'b0);
         @(negedge cr.clk);
         n_cmp++; if (e5 !== (k == 4)) begin n_err++; $display("FAIL rst_warm_en k=%0d got %b want %b", k, e5, (k == 4)); end
      end
      n_cmp++; if (m5 !== 16'd33) begin n_err++; $display("FAIL rst_warm_med got %0d want 33", m5); end
   endtask

   initial begin
      test_reset();
      test_warmup();
      test_signed();
      test_back_to_back();
      test_bypass();
      test_flush();
      test_bypass_warmup();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/median_filter_n.md
MEDIAN_FILTER_N -- requirements
Module: median_filter_n

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 SHALL have parameter WIN, default 5, window length; odd, 3..9; other values SHALL fail elaboration.
REQ-003 SHALL have parameter SIGNED, default 0; 1 = two's-complement compare, 0 = unsigned compare.
REQ-004 inst_in  interface (clk_rst_intrfc)  --  carries inst_in.clk (single clock, rising edge) and inst_in.rstn (asynchronous, active-low reset).
REQ-005 data_i  input  DATA_W  sample, valid when data_av_sync=1.
REQ-006 data_av_sync  input  1  single-cycle sample strobe, already synchronised to inst_in.clk.
REQ-007 flush_i  input  1  clears window contents and fill count.
REQ-008 bypass_i  input  1  mode: 1 = pass sample through unfiltered.
REQ-009 median  output  DATA_W  registered filter result.
REQ-010 median_en  output  1  one-cycle pulse, median valid.
REQ-011 window_full  output  1  level, WIN samples held since last reset/flush.

Function
REQ-012 Window SHALL be a circular buffer of WIN entries with write pointer wrapping WIN-1 -> 0.
REQ-013 On an edge with data_av_sync=1, data_i SHALL be written at the write pointer and the pointer SHALL advance.
REQ-014 Fill count SHALL increment per accepted sample and saturate at WIN; window_full = (count == WIN).
REQ-015 Median SHALL be the element of rank (WIN-1)/2 in ascending order, rank = count of elements strictly less, plus equal elements of lower index (tie-break).
REQ-016 Latency: sample accepted at edge N -> median and median_en=1 registered at edge N+1, median_en low at edge N+2 unless another sample is accepted at N+1.
REQ-017 median_en SHALL pulse only for accepted samples where window_full was 1 after the write (filter mode); during warm-up no pulse and median holds.
REQ-018 Back-to-back strobes (every cycle) SHALL produce one median_en pulse per sample, no loss.
REQ-019 bypass_i=1 at acceptance edge: median SHALL equal that sample at N+1 with median_en pulse regardless of fill; window still updated.
REQ-020 flush_i=1 SHALL clear all entries to 0, write pointer to 0, fill count to 0 at that edge.
REQ-021 flush_i and data_av_sync together: flush first, the sample becomes entry 0, count = 1, no median_en pulse (unless bypass_i=1).
REQ-022 median SHALL hold its last value when median_en=0.
REQ-023 Sorting/compare SHALL honour SIGNED; no arithmetic widening of samples.

Reset
REQ-024 rstn=0 SHALL asynchronously clear: all entries, write pointer, fill count, median=0, median_en=0, window_full=0.
REQ-025 Reset mid-stream SHALL discard the partial window; warm-up restarts after release.
REQ-026 median SHALL be a register output only; no combinational dependence on rstn.

Structure
REQ-027 Shared package median_pkg SHALL hold WIN_MIN=3, WIN_MAX=9, and the pointer/count width function (clog2 of WIN+1).
REQ-028 Rank selection SHALL be a combinational sub-module median_rank_sel (params DATA_W, WIN, SIGNED; input packed window, output selected value).
REQ-029 Top SHALL contain only sequential storage, counters, mode mux and output registers.

Verification
REQ-030 WIN=5, unsigned: strobes 10,50,30,20,40 -> no pulse for first four; pulse after 5th with median=30; next 60 -> median=40.
REQ-031 WIN=3, SIGNED=1: 0xFFFF,0x0002,0x0001 -> median=0x0001; same with SIGNED=0 -> median=0x0002.
REQ-032 WIN=5 ties: 7,7,3,7,3 -> median=7; back-to-back strobes produce consecutive median_en pulses each cycle after fill.
REQ-033 WIN=5 filled, bypass_i=1 with sample 0x1234 -> median=0x1234 next cycle, median_en pulse; bypass_i=0 then sample 0 -> median of updated window.
REQ-034 WIN=5 filled, flush_i with simultaneous sample 9 -> window_full=0, no pulse; four more samples needed before next pulse.
REQ-035 rstn asserted after 3 samples -> all outputs 0 immediately; after release 5 fresh samples required before median_en.
